// File: rtl/fifo_rd_packer.sv
// Packs PACK words from a show-ahead FIFO read port into one wide valid/ready beat; flush closes a partial beat.
// Latency: beat-completing pop in cycle N -> out_valid in N+1. Backpressure: beat held stable, no pops while held.
// Optional: FIFO_RD_PACKER_LAST_EN adds out_last, marking beats closed by flush.
module fifo_rd_packer #(
    parameter int WIDTH = 10,
    parameter int PACK  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [WIDTH-1:0]      fifo_data,
    output logic                  fifo_en,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH*PACK-1:0] out_data,
    output logic [PACK-1:0]       out_keep
`ifdef FIFO_RD_PACKER_LAST_EN
    ,
    output logic                  out_last
`endif
);

    localparam int CW = $clog2(PACK + 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                  state, state_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic [WIDTH*PACK-1:0]   data_q, data_d;
    logic [PACK-1:0]         keep_q, keep_d;
    logic                    pop;
`ifdef FIFO_RD_PACKER_LAST_EN
    logic                    last_q, last_d;
`endif

    assign out_valid = (state == HOLD);
    assign fifo_en   = !fifo_empty && (!out_valid || out_ready) && !rst;
    assign pop       = fifo_en;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
`ifdef FIFO_RD_PACKER_LAST_EN
    assign out_last  = last_q;
`endif

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        data_d  = data_q;
        keep_d  = keep_q;
`ifdef FIFO_RD_PACKER_LAST_EN
        last_d  = last_q;
`endif
        case (state)
            FILL: begin
                if (pop) begin
                    for (int i = 0; i < PACK; i++) begin
                        if (cnt == CW'(i)) begin
                            data_d[i*WIDTH +: WIDTH] = fifo_data;
                            keep_d[i]                = 1'b1;
                        end
                    end
                    cnt_d = cnt + CW'(1);
                end
                // A flush on an empty accumulator with no pop has nothing to close.
                if ((pop && cnt == CW'(PACK - 1)) || (flush && (cnt != '0 || pop))) begin
                    state_d = HOLD;
`ifdef FIFO_RD_PACKER_LAST_EN
                    last_d  = flush;
`endif
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = FILL;
                    data_d  = '0;
                    keep_d  = '0;
                    cnt_d   = '0;
`ifdef FIFO_RD_PACKER_LAST_EN
                    last_d  = 1'b0;
`endif
                    // Word popped in the handshake cycle starts the next beat.
                    if (pop) begin
                        data_d[WIDTH-1:0] = fifo_data;
                        keep_d[0]         = 1'b1;
                        cnt_d             = CW'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FILL;
            cnt    <= '0;
            data_q <= '0;
            keep_q <= '0;
`ifdef FIFO_RD_PACKER_LAST_EN
            last_q <= 1'b0;
`endif
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            data_q <= data_d;
            keep_q <= keep_d;
`ifdef FIFO_RD_PACKER_LAST_EN
            last_q <= last_d;
`endif
        end
    end

endmodule
